fetch_unit: RTL and testbench

Instruction fetch stage for the single-issue RISC-V core. It owns the program counter and drives the word address of the combinational instruction ROM. It captures the returned instruction word into a small fetch queue and presents instructions to decode over a valid/ready handshake. Branch and jump redirects from execute flush the queue and restart fetch at the new target.

---
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage: PC, combinational ROM addressing and
//               a DEPTH-entry fetch queue with a valid/ready decode interface.
//               Define FETCH_PERF_EN to add fetch/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned      DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr_data,
  output logic [WIDTH-1:0] instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  // DEPTH is restricted to 2 or 4, so the pointers wrap naturally.
  localparam int unsigned PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_q_pc   [DEPTH];
  logic [WIDTH-1:0] r_q_data [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_pop;
  logic             w_push;
  logic [WIDTH-1:0] w_redirect_pc;

  assign w_redirect_pc = redirect_pc & ~WIDTH'(3);
  assign w_pop         = (r_count != '0) && instr_ready;
  assign w_push        = !redirect_valid && ((r_count < CNT_W'(DEPTH)) || w_pop);

  assign rom_addr    = {2'b00, r_pc[WIDTH-1:2]};
  assign instr_valid = (r_count != '0);
  assign instr_data  = r_q_data[r_rd_ptr];
  assign instr_pc    = r_q_pc[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      // A same-cycle pop has already been consumed by decode; the flush drops the rest.
      r_pc     <= w_redirect_pc;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + WIDTH'(4);
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_q_pc[i]   <= '0;
        r_q_data[i] <= '0;
      end
    end else if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_pc;
      r_q_data[r_wr_ptr] <= rom_data;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetch_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      end
      if (redirect_valid) begin
        r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = r_perf_fetch_cnt;
  assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit: directed scenarios plus
//               randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        rst;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  // ROM word i holds 0x1000_0000 + i.
  assign rom_data = 32'h1000_0000 + rom_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] byte_pc);
    return 32'h1000_0000 + (byte_pc / 4);
  endfunction

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    #12;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", instr_valid); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", instr_pc); end
    total++; if (instr_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", instr_data); end
    total++; if (rom_addr !== 32'h0) begin bad++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
`ifdef FETCH_PERF_EN
    total++; if (perf_fetch_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin bad++; $display("FAIL reset_perf got=%h/%h exp=0/0", perf_fetch_cnt, perf_flush_cnt); end
`endif
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%0b exp=1", i, instr_valid); end
      total++; if (instr_pc !== 32'(4 * i)) begin bad++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, instr_pc, 32'(4 * i)); end
      total++; if (instr_data !== 32'h1000_0000 + 32'(i)) begin bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, instr_data, 32'h1000_0000 + 32'(i)); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    instr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i >= 1) begin
        total++; if (rom_addr !== 32'h2) begin bad++; $display("FAIL bp_rom_addr[%0d] got=%h exp=2", i, rom_addr); end
        total++; if (instr_pc !== 32'h0 || instr_valid !== 1'b1) begin bad++; $display("FAIL bp_head[%0d] got=%h/%0b exp=0/1", i, instr_pc, instr_valid); end
      end
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      total++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i)) begin bad++; $display("FAIL bp_resume[%0d] got=%h/%0b exp=%h/1", i, instr_pc, instr_valid, 32'(4 * i)); end
      total++; if (instr_data !== 32'h1000_0000 + 32'(i)) begin bad++; $display("FAIL bp_resume_data[%0d] got=%h exp=%h", i, instr_data, 32'h1000_0000 + 32'(i)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    do_reset();
    instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_flush_valid got=%0b exp=0", instr_valid); end
    total++; if (rom_addr !== 32'h40) begin bad++; $display("FAIL redir_rom_addr got=%h exp=40", rom_addr); end
    @(posedge clk); #1;
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin bad++; $display("FAIL redir_target got=%h/%0b exp=100/1", instr_pc, instr_valid); end
    total++; if (instr_data !== 32'h1000_0040) begin bad++; $display("FAIL redir_data got=%h exp=10000040", instr_data); end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin bad++; $display("FAIL rpop_head got=%h/%0b exp=0/1", instr_pc, instr_valid); end
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rpop_flush_valid got=%0b exp=0", instr_valid); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200 + 32'(4 * i)) begin bad++; $display("FAIL rpop_seq[%0d] got=%h/%0b exp=%h/1", i, instr_pc, instr_valid, 32'h200 + 32'(4 * i)); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    do_reset();
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc[i]) begin bad++; $display("FAIL wrap_pc[%0d] got=%h/%0b exp=%h/1", i, instr_pc, instr_valid, exp_pc[i]); end
      total++; if (instr_data !== rom_word(exp_pc[i])) begin bad++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, instr_data, rom_word(exp_pc[i])); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    instr_ready = 1'b1;
    repeat (3) @(posedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    @(posedge clk);
    redirect_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL arst_pre_valid got=%0b exp=1", instr_valid); end
    #1;
    rst = 1'b1;
    #1;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%0b exp=0", instr_valid); end
    total++; if (rom_addr !== 32'h0 || instr_pc !== 32'h0) begin bad++; $display("FAIL arst_pc got=%h/%h exp=0/0", rom_addr, instr_pc); end
`ifdef FETCH_PERF_EN
    total++; if (perf_fetch_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin bad++; $display("FAIL arst_perf got=%h/%h exp=0/0", perf_fetch_cnt, perf_flush_cnt); end
`endif
    @(negedge clk);
    rst = 1'b0;
    instr_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin bad++; $display("FAIL arst_restart got=%h/%0b exp=0/1", instr_pc, instr_valid); end
  endtask

  // Reference: a plain queue of {pc, data} plus the fetch PC.
  task automatic test_random();
    logic [63:0] mq[$];
    logic [31:0] mpc;
    logic [31:0] mfetch;
    logic [31:0] mflush;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    do_reset();
    mpc    = 32'h0;
    mfetch = 0;
    mflush = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      total++; if (instr_valid !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_valid[%0d] got=%0b exp=%0b", cyc, instr_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        total++; if ({instr_pc, instr_data} !== mq[0]) begin bad++; $display("FAIL rnd_head[%0d] got=%h_%h exp=%h", cyc, instr_pc, instr_data, mq[0]); end
      end
      total++; if (rom_addr !== mpc / 4) begin bad++; $display("FAIL rnd_rom_addr[%0d] got=%h exp=%h", cyc, rom_addr, mpc / 4); end
`ifdef FETCH_PERF_EN
      total++; if (perf_fetch_cnt !== mfetch || perf_flush_cnt !== mflush) begin bad++; $display("FAIL rnd_perf[%0d] got=%h/%h exp=%h/%h", cyc, perf_fetch_cnt, perf_flush_cnt, mfetch, mflush); end
`endif
      rdy = ($urandom_range(0, 9) < 6);
      rv  = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      instr_ready    = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      if (mq.size() != 0 && rdy) begin
        void'(mq.pop_front());
        mfetch++;
      end
      if (rv) begin
        mq.delete();
        mpc = rpc & 32'hFFFF_FFFC;
        mflush++;
      end else if (mq.size() < DEPTH) begin
        mq.push_back({mpc, rom_word(mpc)});
        mpc = mpc + 4;
      end
      @(posedge clk);
      @(negedge clk);
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
